// File: rtl/pe_os_booth8_acc.sv
// Output-stationary radix-8 Booth PE: forwards pre-encoded digits and operands,
// forms the product from the digit groups and accumulates it with optional saturation.
module pe_os_booth8_acc #(
  parameter int WIDTH = 8,
  parameter int GUARD = 4,
  parameter bit SAT   = 1'b1,
  localparam int GC    = (WIDTH+2)/3,
  localparam int ACC_W = 2*WIDTH+GUARD
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [GC-1:0]           s,
  input  logic [GC-1:0]           d,
  input  logic [GC-1:0]           t,
  input  logic [GC-1:0]           q,
  input  logic [GC-1:0]           n,
  input  logic signed [WIDTH-1:0] Y,
  input  logic signed [WIDTH+1:0] TMY,
  input  logic                    VLD_IN,
  input  logic                    CLR_IN,
  input  logic                    DRAIN,
  input  logic [ACC_W-1:0]        ACC_IN,
  input  logic                    OVF_IN,
  output logic [GC-1:0]           S_OUT,
  output logic [GC-1:0]           D_OUT,
  output logic [GC-1:0]           T_OUT,
  output logic [GC-1:0]           Q_OUT,
  output logic [GC-1:0]           N_OUT,
  output logic [WIDTH-1:0]        Y_OUT,
  output logic [WIDTH+1:0]        TMY_OUT,
  output logic                    VLD_OUT,
  output logic                    CLR_OUT,
  output logic signed [ACC_W-1:0] MAC_OUT,
  output logic                    OVF_OUT
);

  localparam int PW    = 2*WIDTH;
  localparam int SUM_W = ACC_W+1;

  // Product is built modulo 2^PW: the true product always fits, so wrap in the
  // partial terms cancels out.
  logic signed [PW-1:0] y_x, tmy_x, mag, term, psum;
  assign y_x   = PW'(Y);
  assign tmy_x = PW'(TMY);

  always_comb begin
    psum = '0;
    mag  = '0;
    term = '0;
    for (int g = 0; g < GC; g++) begin
      if (s[g])      mag = y_x;
      else if (d[g]) mag = y_x <<< 1;
      else if (t[g]) mag = tmy_x;
      else if (q[g]) mag = y_x <<< 2;
      else           mag = '0;
      term = n[g] ? -mag : mag;
      psum = psum + (term <<< (3*g));
    end
  end

  logic signed [PW-1:0] prod_q;
  logic                 pv_q, pc_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prod_q  <= '0;
      pv_q    <= 1'b0;
      pc_q    <= 1'b0;
      S_OUT   <= '0;
      D_OUT   <= '0;
      T_OUT   <= '0;
      Q_OUT   <= '0;
      N_OUT   <= '0;
      Y_OUT   <= '0;
      TMY_OUT <= '0;
      VLD_OUT <= 1'b0;
      CLR_OUT <= 1'b0;
    end else begin
      prod_q  <= psum;
      pv_q    <= VLD_IN;
      pc_q    <= CLR_IN;
      S_OUT   <= s;
      D_OUT   <= d;
      T_OUT   <= t;
      Q_OUT   <= q;
      N_OUT   <= n;
      Y_OUT   <= Y;
      TMY_OUT <= TMY;
      VLD_OUT <= VLD_IN;
      CLR_OUT <= CLR_IN;
    end
  end

  logic signed [ACC_W-1:0] prod_x, sat_val;
  logic signed [SUM_W-1:0] sum;
  logic                    ovf;

  assign prod_x  = ACC_W'(prod_q);
  assign sum     = SUM_W'(MAC_OUT) + SUM_W'(prod_x);
  assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
  // Clamp toward the true sign, carried in the extra top bit.
  assign sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MAC_OUT <= '0;
      OVF_OUT <= 1'b0;
    end else if (DRAIN) begin
      MAC_OUT <= ACC_IN;
      OVF_OUT <= OVF_IN;
    end else if (pv_q) begin
      if (pc_q) begin
        MAC_OUT <= prod_x;
        OVF_OUT <= 1'b0;
      end else begin
        MAC_OUT <= (ovf && SAT) ? sat_val : sum[ACC_W-1:0];
        if (ovf) OVF_OUT <= 1'b1;
      end
    end
  end

endmodule
